// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect inputs, IF/ID outputs.
// FETCH_PERF_CNT_EN adds the stall/flush performance counters.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              stall_if;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc4;
  logic              if_id_valid;
  logic              halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  modport master (
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted,
`ifdef FETCH_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    input  imem_data, stall_if, branch_taken, branch_target, jump, jump_target
  );

  modport slave (
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted,
`ifdef FETCH_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    output imem_data, stall_if, branch_taken, branch_target, jump, jump_target
  );
endinterface

// File: rtl/fetch_ctrl.sv
// MIPS32 instruction-fetch controller: PC, IF/ID register, stall/redirect/halt.
// FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h000,
  parameter logic [ADDR_W-1:0] END_PC   = 'h104
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_plus4, redir_raw, redir_pc;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              valid_q;
  logic              redirect, flush_en, fetch_en, halt_en, stall_act;

  // Branch is older than jump, so it owns the target when both fire.
  assign redirect  = bus.branch_taken | bus.jump;
  assign redir_raw = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign redir_pc  = redir_raw & ~ADDR_W'(3);
  assign pc_plus4  = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN:  if (!redirect && !bus.stall_if && pc_q == END_PC) state_nxt = S_HALT;
      S_HALT: if (redirect) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    flush_en  = 1'b0;
    fetch_en  = 1'b0;
    halt_en   = 1'b0;
    stall_act = 1'b0;
    case (state)
      S_RUN: begin
        flush_en  = redirect;
        stall_act = !redirect && bus.stall_if;
        halt_en   = !redirect && !bus.stall_if && pc_q == END_PC;
        fetch_en  = !redirect && !bus.stall_if && pc_q != END_PC;
      end
      // A redirect reaching HALT comes from an older instruction still in flight.
      S_HALT:  flush_en = redirect;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_en) begin
      pc_q    <= redir_pc;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (fetch_en) begin
      pc_q    <= pc_plus4;
      instr_q <= bus.imem_data;
      pc4_q   <= pc_plus4;
      valid_q <= 1'b1;
    end else if (halt_en) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_act && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_en  && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a reference model feeding a scoreboard queue.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_ctrl_if #(.ADDR_W(10)) bus ();

  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [9:0] a);
    return {6'h2B, a, 6'h15, a};
  endfunction

  assign bus.imem_data = word_at(bus.imem_addr);

  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [9:0]  pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  int          m_st;
  logic [9:0]  m_pc, m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] m_stall, m_flush;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 10'h000; m_pc4 = 10'h000; m_instr = 32'h0; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    m_stall = 16'h0; m_flush = 16'h0;
`endif
  endtask

  // Drive one cycle of inputs, predict the post-edge state, compare after the edge.
  task automatic step(input logic b, input logic [9:0] bt, input logic j,
                      input logic [9:0] jt, input logic s);
    exp_t e;
    logic [9:0] tgt;
    bus.branch_taken = b; bus.branch_target = bt;
    bus.jump = j; bus.jump_target = jt; bus.stall_if = s;
    tgt = (b ? bt : jt) & 10'h3FC;
    case (m_st)
      0: m_st = 1;
      1: begin
        if (b || j) begin
          m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
          if (m_flush != 16'hFFFF) m_flush++;
`endif
        end else if (s) begin
`ifdef FETCH_PERF_CNT_EN
          if (m_stall != 16'hFFFF) m_stall++;
`endif
        end else if (m_pc == 10'h104) begin
          m_st = 2; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
          m_instr = word_at(m_pc); m_pc4 = m_pc + 10'd4; m_valid = 1'b1; m_pc = m_pc + 10'd4;
        end
      end
      default: begin
        if (b || j) begin
          m_pc = tgt; m_st = 1;
`ifdef FETCH_PERF_CNT_EN
          if (m_flush != 16'hFFFF) m_flush++;
`endif
        end
      end
    endcase
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.halted = (m_st == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.stall_if = 1'b0;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", 32'(bus.pc), 32'(e.pc));
      chk("imem_addr", 32'(bus.imem_addr), 32'(e.pc));
      chk("if_id_instr", bus.if_id_instr, e.instr);
      chk("if_id_pc4", 32'(bus.if_id_pc4), 32'(e.pc4));
      chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
      chk("halted", 32'(bus.halted), 32'(e.halted));
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
`endif
    end
  endtask

  task automatic idle();
    step(1'b0, 10'h0, 1'b0, 10'h0, 1'b0);
  endtask

  task automatic run_to(input logic [9:0] target);
    int n = 0;
    while (m_pc != target && n < 300) begin
      idle();
      n++;
    end
    chk("run_to_reached", 32'(bus.pc), 32'(target));
  endtask

  initial begin
    bus.stall_if = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0; bus.jump_target = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_instr", bus.if_id_instr, 32'h0);
    chk("rst_pc4", 32'(bus.if_id_pc4), 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    chk("boot_valid", 32'(bus.if_id_valid), 32'h0);

    // BOOT -> RUN, then first valid fetch two cycles after release
    idle();
    chk("run_pc", 32'(bus.pc), 32'h000);
    chk("run_valid", 32'(bus.if_id_valid), 32'h0);
    idle();
    chk("first_instr", bus.if_id_instr, word_at(10'h000));
    chk("first_pc4", 32'(bus.if_id_pc4), 32'h004);
    chk("first_valid", 32'(bus.if_id_valid), 32'h1);
    repeat (3) idle();
    chk("seq_pc", 32'(bus.pc), 32'h010);
    chk("seq_instr3", bus.if_id_instr, word_at(10'h00C));

    // Single-cycle stall
    run_to(10'h0BC);
    step(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
    chk("stall_pc_hold", 32'(bus.pc), 32'h0BC);
    chk("stall_instr_hold", bus.if_id_instr, word_at(10'h0B8));
    idle();
    chk("stall_resume_pc", 32'(bus.pc), 32'h0C0);
    chk("stall_resume_instr", bus.if_id_instr, word_at(10'h0BC));

    // Branch flush
    run_to(10'h0D8);
    step(1'b1, 10'h0E0, 1'b0, 10'h0, 1'b0);
    chk("br_pc", 32'(bus.pc), 32'h0E0);
    chk("br_bubble", bus.if_id_instr, 32'h0);
    idle();
    chk("br_target_instr", bus.if_id_instr, word_at(10'h0E0));
    chk("br_target_pc4", 32'(bus.if_id_pc4), 32'h0E4);

    // Branch beats jump beats stall
    step(1'b1, 10'h040, 1'b1, 10'h100, 1'b1);
    chk("prio_pc", 32'(bus.pc), 32'h040);
    chk("prio_valid", 32'(bus.if_id_valid), 32'h0);
    idle();
    chk("prio_instr", bus.if_id_instr, word_at(10'h040));

    // Misaligned jump target and PC wrap
    step(1'b0, 10'h0, 1'b1, 10'h3FF, 1'b0);
    chk("jmp_align_pc", 32'(bus.pc), 32'h3FC);
    idle();
    chk("wrap_pc", 32'(bus.pc), 32'h000);
    chk("wrap_pc4", 32'(bus.if_id_pc4), 32'h000);

    // Redirect to END_PC halts on the following cycle
    step(1'b0, 10'h0, 1'b1, 10'h104, 1'b0);
    chk("jmp_end_not_halted", 32'(bus.halted), 32'h0);
    idle();
    chk("jmp_end_halted", 32'(bus.halted), 32'h1);

    // Sequential run into END_PC, stall ignored in HALT, jump back out
    step(1'b0, 10'h0, 1'b1, 10'h0F0, 1'b0);
    run_to(10'h104);
    idle();
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_pc", 32'(bus.pc), 32'h104);
    step(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
    idle();
    chk("halt_hold_pc", 32'(bus.pc), 32'h104);
    chk("halt_hold_valid", 32'(bus.if_id_valid), 32'h0);
    step(1'b0, 10'h0, 1'b1, 10'h000, 1'b0);
    chk("unhalt", 32'(bus.halted), 32'h0);
    idle();
    chk("unhalt_instr", bus.if_id_instr, word_at(10'h000));

    // Asynchronous reset mid-operation
    repeat (3) idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'h0);
    chk("async_rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("async_rst_instr", bus.if_id_instr, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    chk("rerun_instr", bus.if_id_instr, word_at(10'h000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the MIPS32 pipeline. It owns the program counter, drives the combinational instruction memory's byte address, and loads the IF/ID pipeline register. It applies load-use stalls from the hazard unit, redirects on taken branches and jumps with a one-slot flush, and halts at a configured end-of-program address.

## Interface
Parameters:
- ADDR_W, 10, byte-address width of instruction memory (256 words)
- RESET_PC, 10'h000, PC value after reset
- END_PC, 10'h104, first address past the program; fetch halts on reaching it

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  byte address to instruction memory; equals pc
- imem_data  in  32  instruction word, combinational from imem_addr
- stall_if  in  1  hazard unit: hold PC and IF/ID this cycle
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  ADDR_W  branch destination (byte address)
- jump  in  1  jump decoded this cycle
- jump_target  in  ADDR_W  jump destination (byte address)
- pc  out  ADDR_W  current fetch PC
- if_id_instr  out  32  IF/ID instruction (32'h0 = NOP when invalid)
- if_id_pc4  out  ADDR_W  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  FSM in HALT

## Operation
- FSM states: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: lasts exactly one cycle; imem_addr=RESET_PC; IF/ID stays invalid; next state is RUN.
- RUN, per-cycle priority: branch_taken > jump > stall_if > halt check > normal fetch.
- Normal fetch: if_id_instr<=imem_data, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4.
- Stall: pc, if_id_instr, if_id_pc4 and if_id_valid hold their values.
- Redirect (branch or jump): pc<=target with bits [1:0] forced to 0; if_id_instr<=0; if_id_valid<=0. A redirect overrides a simultaneous stall_if. Branch is older than jump, so a branch wins when both are asserted.
- Halt check: in RUN, when pc==END_PC and no redirect: go to HALT, if_id_valid<=0, if_id_instr<=0.
- HALT: pc holds; IF/ID stays invalid; stall_if is ignored. A redirect in HALT, from an older instruction still in flight, loads the target and returns to RUN.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- A redirect to END_PC halts on the following cycle.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, state=BOOT.
- Reset is asynchronous assert and synchronous release. Assertion mid-operation clears all state within the same cycle.
- Fetch latency: the word at pc appears in IF/ID one cycle after pc is presented. The first valid IF/ID occurs 2 cycles after rst_n deasserts.
- Redirect: pc=target on the edge after the request. The target instruction is valid in IF/ID one cycle later. Exactly one bubble is inserted.
- halted rises on the edge that enters HALT.
- All inputs are sampled on the rising edge.
- imem_data must be stable within the same cycle as imem_addr.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds output stall_cnt (16 bits), counting RUN cycles with stall_if applied.
  - Adds output flush_cnt (16 bits), counting redirects.
  - Both counters saturate at 16'hFFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset and boot: hold rst_n=0 for 3 cycles, then release. Required: pc=0 and valid=0 in BOOT. Next cycle pc=0 and RUN. Following edge: if_id_instr=word at 0x000, if_id_pc4=0x004, valid=1.
- Sequential fetch: run 4 cycles unstalled. Required: pc steps 0x000→0x004→0x008→0x00C; IF/ID carries words 0–3 in order.
- Stall: assert stall_if for 1 cycle at pc=0x0BC. Required: pc and IF/ID hold for exactly one cycle, then fetch resumes at 0x0C0.
- Branch flush: branch_taken=1 with target 0x0E0 while pc=0x0D8. Required: next pc=0x0E0, valid=0, instr=0. The cycle after, IF/ID holds the word at 0x0E0 with pc4=0x0E4.
- Priority: assert branch_taken (target 0x040), jump (target 0x100) and stall_if together. Required: pc=0x040, one bubble. With FETCH_PERF_CNT_EN: flush_cnt increments by 1 and stall_cnt is unchanged.
- Halt: run to pc=0x104. Required: halted=1 next cycle, valid stays 0, pc stays 0x104. Then jump to 0x000: RUN resumes, halted=0.
